// File: rtl/regfile_write_sched.sv
// regfile_write_sched: arbitrates the register file's single write port between ALU and load
// writeback, sequences link (R14) strobes and tracks pending writes for hazard stalls.
module regfile_write_sched #(
   parameter int DEPTH = 4
) (
   input  logic        i_clock,
   input  logic        i_R,
   input  logic        i_alu_valid,
   input  logic [3:0]  i_alu_rd,
   input  logic [31:0] i_alu_data,
   output logic        o_alu_ready,
   input  logic        i_mem_valid,
   input  logic [3:0]  i_mem_rd,
   input  logic [31:0] i_mem_data,
   input  logic        i_bl_valid,
   output logic        o_Ld,
   output logic [3:0]  o_decode_input,
   output logic [31:0] o_Ds,
   output logic        o_BL,
   output logic [15:0] o_pending,
   output logic        o_err
);
   localparam int AW = $clog2(DEPTH);

   logic [3:0]       r_rd   [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [AW-1:0]    r_wp, r_rp;
   logic [AW:0]      r_cnt;
   logic             r_ld, r_bl, r_err;
   logic [3:0]       r_di;
   logic [31:0]      r_ds;
   logic             w_push, w_keep, w_mem_ok, w_pop, w_issue, w_err;
   logic [15:0]      w_pend;

   assign o_alu_ready = r_cnt < (AW+1)'(DEPTH);
   assign w_push      = i_alu_valid && o_alu_ready;
   // an accepted ALU write is discarded when a same-edge mem or link write is younger, or it targets R15
   assign w_keep   = w_push && i_alu_rd != 4'd15 && !(i_mem_valid && i_alu_rd == i_mem_rd)
                     && !(i_bl_valid && i_alu_rd == 4'd14);
   assign w_mem_ok = i_mem_valid && i_mem_rd != 4'd15 && !(i_bl_valid && i_mem_rd == 4'd14);
   assign w_pop    = !w_mem_ok && r_cnt != '0;
   assign w_issue  = w_pop && r_vld[r_rp] && !(i_bl_valid && r_rd[r_rp] == 4'd14);
   assign w_err    = (w_push && i_alu_rd == 4'd15) || (i_mem_valid && i_mem_rd == 4'd15);

   always_ff @(posedge i_clock or posedge i_R) begin
      if (i_R) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= '0;
            r_data[i] <= '0;
         end
         r_vld <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ld  <= 1'b0;
         r_di  <= '0;
         r_ds  <= '0;
         r_bl  <= 1'b0;
         r_err <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            r_vld[i] <= r_vld[i] && !(i_mem_valid && r_rd[i] == i_mem_rd)
                        && !(i_bl_valid && r_rd[i] == 4'd14);
         if (w_pop) begin
            r_vld[r_rp] <= 1'b0;
            r_rp        <= r_rp + 1'b1;
         end
         if (w_keep) begin
            r_rd[r_wp]   <= i_alu_rd;
            r_data[r_wp] <= i_alu_data;
            r_vld[r_wp]  <= 1'b1;
            r_wp         <= r_wp + 1'b1;
         end
         r_cnt <= r_cnt + (AW+1)'(w_keep) - (AW+1)'(w_pop);
         r_ld  <= w_mem_ok || w_issue;
         if (w_mem_ok) begin
            r_di <= i_mem_rd;
            r_ds <= i_mem_data;
         end else if (w_issue) begin
            r_di <= r_rd[r_rp];
            r_ds <= r_data[r_rp];
         end
         r_bl  <= i_bl_valid;
         r_err <= w_err;
      end
   end

   always_comb begin
      w_pend = '0;
      for (int i = 0; i < DEPTH; i++)
         if (r_vld[i]) w_pend[r_rd[i]] = 1'b1;
      if (r_ld) w_pend[r_di] = 1'b1;
      if (r_bl) w_pend[14] = 1'b1;
   end

   assign o_pending      = w_pend;
   assign o_Ld           = r_ld;
   assign o_decode_input = r_di;
   assign o_Ds           = r_ds;
   assign o_BL           = r_bl;
   assign o_err          = r_err;
endmodule

// File: tb/tb_regfile_write_sched.sv
// tb_regfile_write_sched: directed stimulus with a write scoreboard checked on every Ld cycle.
module tb_regfile_write_sched;
   logic        clk = 1'b0, rst = 1'b1;
   logic        alu_valid, mem_valid, bl_valid, alu_ready, ld, bl, err;
   logic [3:0]  alu_rd, mem_rd, di;
   logic [31:0] alu_data, mem_data, ds;
   logic [15:0] pending;
   int          total = 0, bad = 0;

   typedef struct packed {logic [3:0] rd; logic [31:0] data;} wr_t;
   wr_t sb[$];
   wr_t alu_q[$];

   regfile_write_sched #(.DEPTH(4)) dut (
      .i_clock(clk), .i_R(rst),
      .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
      .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
      .i_bl_valid(bl_valid),
      .o_Ld(ld), .o_decode_input(di), .o_Ds(ds), .o_BL(bl), .o_pending(pending), .o_err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                        input logic b);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      bl_valid  = b;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
   endtask

   // every Ld cycle must match the oldest expected write
   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      if (ld === 1'b1) begin
         chk("ld_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ld_rd", 32'(di), 32'(e.rd));
            chk("ld_data", ds, e.data);
         end
      end
   endtask

   initial begin
      int  cnt, nacc;
      logic mv, av, acc, pop;
      idle();
      repeat (2) tick();
      chk("rst_ld", 32'(ld), 32'd0);
      chk("rst_di", 32'(di), 32'd0);
      chk("rst_ds", ds, 32'd0);
      chk("rst_bl", 32'(bl), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_ready", 32'(alu_ready), 32'd1);
      rst = 1'b0;
      tick();

      // single ALU write: accept, issue next edge, visible one cycle
      drive(1'b1, 4'd3, 32'h11111111, 1'b0, 4'd0, 32'd0, 1'b0);
      sb.push_back('{rd: 4'd3, data: 32'h11111111});
      tick();
      idle();
      chk("alu_acc_ld", 32'(ld), 32'd0);
      chk("alu_acc_pend", 32'(pending), 32'h0008);
      tick();
      chk("alu_iss_ld", 32'(ld), 32'd1);
      chk("alu_iss_pend", 32'(pending), 32'h0008);
      tick();
      chk("alu_done_ld", 32'(ld), 32'd0);
      chk("alu_done_pend", 32'(pending), 32'd0);

      // mem beats same-edge ALU; ALU follows next edge
      drive(1'b1, 4'd6, 32'h06060606, 1'b1, 4'd5, 32'hAAAA0000, 1'b0);
      sb.push_back('{rd: 4'd5, data: 32'hAAAA0000});
      sb.push_back('{rd: 4'd6, data: 32'h06060606});
      tick();
      idle();
      chk("prio_mem_ld", 32'(ld), 32'd1);
      tick();
      chk("prio_alu_ld", 32'(ld), 32'd1);
      tick();
      chk("prio_idle_ld", 32'(ld), 32'd0);

      // queued R2 writes squashed by a younger mem R2
      drive(1'b1, 4'd2, 32'h1, 1'b1, 4'd7, 32'h77, 1'b0);
      sb.push_back('{rd: 4'd7, data: 32'h77});
      tick();
      drive(1'b1, 4'd2, 32'h2, 1'b1, 4'd8, 32'h88, 1'b0);
      sb.push_back('{rd: 4'd8, data: 32'h88});
      tick();
      chk("sq_pend_q", 32'(pending), 32'h0104);
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h3, 1'b0);
      sb.push_back('{rd: 4'd2, data: 32'h3});
      tick();
      idle();
      chk("sq_pend_mem", 32'(pending), 32'h0004);
      tick();
      chk("sq_skip1_ld", 32'(ld), 32'd0);
      chk("sq_skip1_pend", 32'(pending), 32'd0);
      tick();
      chk("sq_skip2_ld", 32'(ld), 32'd0);

      // link beats queued ALU R14 and same-edge mem R14
      drive(1'b1, 4'd14, 32'hBEEF, 1'b1, 4'd9, 32'h99, 1'b0);
      sb.push_back('{rd: 4'd9, data: 32'h99});
      tick();
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 32'hDEAD, 1'b1);
      tick();
      idle();
      chk("bl_strobe", 32'(bl), 32'd1);
      chk("bl_no_ld", 32'(ld), 32'd0);
      chk("bl_pend", 32'(pending), 32'h4000);
      tick();
      chk("bl_clear", 32'(bl), 32'd0);
      chk("bl_pend_clear", 32'(pending), 32'd0);
      chk("bl_after_ld", 32'(ld), 32'd0);

      // sustained mem starves the queue; then the queue drains in order
      cnt = 0;
      nacc = 0;
      for (int e = 1; e <= 12; e++) begin
         mv = (e <= 6);
         av = (nacc < 6);
         drive(av, 4'(nacc + 1), 32'(32'h100 + nacc + 1), mv, 4'd9, 32'(32'h9000 + e), 1'b0);
         if (mv) sb.push_back('{rd: 4'd9, data: 32'(32'h9000 + e)});
         acc = av && cnt < 4;
         pop = !mv && cnt > 0;
         if (acc) begin
            alu_q.push_back('{rd: 4'(nacc + 1), data: 32'(32'h100 + nacc + 1)});
            nacc++;
         end
         cnt = cnt + int'(acc) - int'(pop);
         tick();
         chk($sformatf("burst_ready_%0d", e), 32'(alu_ready), 32'(cnt < 4));
         chk($sformatf("burst_ld_%0d", e), 32'(ld), 32'd1);
         if (e >= 6) while (alu_q.size() != 0) sb.push_back(alu_q.pop_front());
      end
      idle();
      tick();
      chk("burst_end_ld", 32'(ld), 32'd0);
      chk("burst_sb_empty", 32'(sb.size()), 32'd0);

      // R15 writes dropped with one err pulse each edge
      drive(1'b1, 4'd15, 32'hF00D, 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
      idle();
      chk("r15_err", 32'(err), 32'd1);
      chk("r15_no_ld", 32'(ld), 32'd0);
      tick();
      chk("r15_err_clear", 32'(err), 32'd0);
      chk("r15_no_issue", 32'(ld), 32'd0);
      drive(1'b1, 4'd15, 32'h1, 1'b1, 4'd15, 32'h2, 1'b0);
      tick();
      idle();
      chk("r15_both_err", 32'(err), 32'd1);
      tick();
      chk("r15_both_clear", 32'(err), 32'd0);

      // reset with three queued writes discards everything
      for (int e = 1; e <= 3; e++) begin
         drive(1'b1, 4'(e), 32'(32'hC00 + e), 1'b1, 4'd9, 32'(32'hA0 + e), 1'b0);
         sb.push_back('{rd: 4'd9, data: 32'(32'hA0 + e)});
         tick();
      end
      idle();
      chk("pre_rst_pend", 32'(pending), 32'h020E);
      rst = 1'b1;
      #1;
      chk("arst_ld", 32'(ld), 32'd0);
      chk("arst_pend", 32'(pending), 32'd0);
      chk("arst_ready", 32'(alu_ready), 32'd1);
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk($sformatf("post_rst_ld_%0d", e), 32'(ld), 32'd0);
      end
      chk("post_rst_pend", 32'(pending), 32'd0);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
